regfile_write_scheduler: RTL and testbench
==========================================

# regfile_write_scheduler

Shares the single register-file write port between two requesters (ALU writeback, load writeback) using round-robin arbitration with a valid/ready handshake. Each accepted write is decoded into a one-hot per-register enable and registered for one cycle. That enable drives the enable inputs of the enable-flop register bank. The top register is the hardwired zero register, so writes to it are accepted and discarded.

## Interface
- NREGS, 32, number of architectural registers; register NREGS-1 is the zero register
- ADDR_W, 5, register address width; NREGS <= 2**ADDR_W
- DATA_W, 64, write data width

- clk  input  1  system clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset; clears all state at the next posedge
- stall  input  1  pipeline stall; while 1, no grants are issued
- req0_valid  input  1  requester 0 (ALU writeback) has a write
- req0_addr  input  ADDR_W  requester 0 destination register
- req0_data  input  DATA_W  requester 0 write data
- req0_ready  output  1  requester 0 write accepted this cycle
- req1_valid  input  1  requester 1 (load writeback) has a write
- req1_addr  input  ADDR_W  requester 1 destination register
- req1_data  input  DATA_W  requester 1 write data
- req1_ready  output  1  requester 1 write accepted this cycle
- wr_en  output  NREGS  one-hot register enable; all zero when idle
- wr_data  output  DATA_W  data broadcast to every register input
- last_grant  output  1  identity of the most recent granted requester (0 or 1)

## Operation
- Transfer on requester N happens in cycle t when reqN_valid=1 and reqN_ready=1 at the posedge ending t.
- readyN is combinational from valid, stall and the priority pointer. It is never asserted when reqN_valid=0 or stall=1.
- At most one ready is high per cycle.
- Arbitration when not stalled:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester that is not last_grant is granted.
  - Neither valid: no grant; last_grant holds.
- A grant updates last_grant to the granted index at the posedge.
- Output stage (registered):
  - On a transfer with addr < NREGS-1: wr_en <= one-hot(addr) and wr_data <= data.
  - On a transfer with addr = NREGS-1, or addr >= NREGS: wr_en <= 0 and wr_data <= data. The write is accepted and dropped, and ready is still asserted.
  - With no transfer: wr_en <= 0 and wr_data holds its previous value.
- A requester must hold valid, addr and data stable until ready. The block does not buffer unaccepted requests.
- Both requesters targeting the same register in consecutive grants produce two back-to-back wr_en pulses, and the later write wins.

## Timing
- Reset values: wr_en=0, wr_data=0, last_grant=1 (requester 0 wins the first contention), req0_ready=req1_ready=0 while reset=1.
- During reset=1, no transfer occurs. A write presented in the reset cycle is dropped and must be re-presented.
- Latency: accept at edge t, then wr_en is visible during cycle t+1. The register bank captures at edge t+1. Data is readable from the register after edge t+1.
- Throughput: one write per cycle.
- Under continuous contention, grants alternate 0,1,0,1… and no requester waits more than one cycle.
- stall high in cycle t:
  - No grant in cycle t; wr_en=0 in cycle t+1.
  - last_grant is unchanged.
  - A write already registered at edge t-1 still appears in cycle t; the stall does not cancel it.
- Deassertion of reset takes effect at the next posedge. The first grant is possible in the first cycle with reset=0.

## Test plan
- Reset with both valids high: ready0=ready1=0 during reset, and wr_en=0, wr_data=0, last_grant=1 after the reset edge.
- req0 only, addr=3, data=0xAA: ready0=1 in the same cycle, then wr_en=0x0000_0008 and wr_data=0xAA in the next cycle only.
- Both valid for 4 cycles, addr0=1, addr1=2: grant order is 0,1,0,1 and wr_en sequence is 0x2,0x4,0x2,0x4 delayed by one cycle.
- req1 with addr=31, data=0x55: ready1=1, wr_en stays 0 in the next cycle, and last_grant=1.
- stall=1 for 2 cycles with both valid: both readys are 0, wr_en=0 after the in-flight write drains, and last_grant is unchanged. After stall=0, the requester that was not last_grant is granted first.
- reset asserted in the cycle req0 is accepted-eligible: no ready, and wr_en=0 next cycle. After reset drops, the same request completes normally.

Source files
------------

// File: rtl/regfile_write_scheduler.sv
// Round-robin arbiter sharing the register-file write port between ALU and load
// writeback, with a registered one-hot enable stage for an enable-flop register bank.
module regfile_write_scheduler #(
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [NREGS-1:0]  wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              last_grant
);

  logic              grant0;
  logic              grant1;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [NREGS-1:0]  dec_en;

  // Contention goes to whichever requester was not granted last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset && !stall) begin
      grant0 = req0_valid && (!req1_valid || last_grant);
      grant1 = req1_valid && (!req0_valid || !last_grant);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Zero register and out-of-range addresses decode to no enable at all.
  always_comb begin
    sel_addr = grant1 ? req1_addr : req0_addr;
    sel_data = grant1 ? req1_data : req0_data;
    dec_en   = '0;
    for (int unsigned i = 0; i < NREGS - 1; i++) begin
      if (sel_addr == ADDR_W'(i)) dec_en[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en      <= '0;
      wr_data    <= '0;
      last_grant <= 1'b1;
    end else if (grant0 || grant1) begin
      wr_en      <= dec_en;
      wr_data    <= sel_data;
      last_grant <= grant1;
    end else begin
      wr_en <= '0;
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler: stimulus queues expected register
// writes, a monitor pops them whenever wr_en is non-zero.
module tb_regfile_write_scheduler;

  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              stall = 1'b0;
  logic              req0_valid = 1'b0;
  logic [ADDR_W-1:0] req0_addr = '0;
  logic [DATA_W-1:0] req0_data = '0;
  logic              req0_ready;
  logic              req1_valid = 1'b0;
  logic [ADDR_W-1:0] req1_addr = '0;
  logic [DATA_W-1:0] req1_data = '0;
  logic              req1_ready;
  logic [NREGS-1:0]  wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              last_grant;

  typedef struct {
    logic [NREGS-1:0]  en;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  fails  = 0;

  regfile_write_scheduler #(.NREGS(NREGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .wr_en(wr_en), .wr_data(wr_data), .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [NREGS-1:0] en, input logic [DATA_W-1:0] data);
    wr_t w;
    w.en   = en;
    w.data = data;
    sb.push_back(w);
  endtask

  // One cycle: drive just after the edge, then check the combinational readies.
  task automatic cyc(input logic rst, input logic st,
                     input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                     input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                     input logic er0, input logic er1, input string tag);
    @(posedge clk);
    #1;
    reset = rst; stall = st;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    #1;
    chk({tag, "_ready0"}, 64'(req0_ready), 64'(er0));
    chk({tag, "_ready1"}, 64'(req1_ready), 64'(er1));
  endtask

  task automatic idle(input string tag);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, tag);
  endtask

  // Monitor: every non-zero enable must match the oldest expected write.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (wr_en != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_wr_en", 64'(wr_en), 64'h0);
        end else begin
          w = sb.pop_front();
          chk("sb_wr_en", 64'(wr_en), 64'(w.en));
          chk("sb_wr_data", wr_data, w.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with both requesters valid
    cyc(1'b1, 1'b0, 1'b1, 5'd1, 64'h1, 1'b1, 5'd2, 64'h2, 1'b0, 1'b0, "rst");
    idle("post_rst");
    chk("rst_wr_en", 64'(wr_en), 64'h0);
    chk("rst_wr_data", wr_data, 64'h0);
    chk("rst_last_grant", 64'(last_grant), 64'h1);

    // Single requester 0 write to r3
    cyc(1'b0, 1'b0, 1'b1, 5'd3, 64'hAA, 1'b0, '0, '0, 1'b1, 1'b0, "r0_only");
    push(32'h0000_0008, 64'hAA);
    idle("r0_after");
    chk("r0_last_grant", 64'(last_grant), 64'h0);
    idle("r0_after2");
    chk("r0_pulse_once", 64'(wr_en), 64'h0);
    chk("r0_data_hold", wr_data, 64'hAA);

    // Requester 1 targets the zero register: accepted and dropped
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 5'd31, 64'h55, 1'b0, 1'b1, "zero_reg");
    idle("zero_after");
    chk("zero_wr_en", 64'(wr_en), 64'h0);
    chk("zero_wr_data", wr_data, 64'h55);
    chk("zero_last_grant", 64'(last_grant), 64'h1);

    // Continuous contention alternates 0,1,0,1
    cyc(1'b0, 1'b0, 1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22, 1'b1, 1'b0, "cont0");
    push(32'h2, 64'h11);
    cyc(1'b0, 1'b0, 1'b1, 5'd1, 64'h13, 1'b1, 5'd2, 64'h22, 1'b0, 1'b1, "cont1");
    push(32'h4, 64'h22);
    cyc(1'b0, 1'b0, 1'b1, 5'd1, 64'h13, 1'b1, 5'd2, 64'h24, 1'b1, 1'b0, "cont2");
    push(32'h2, 64'h13);
    cyc(1'b0, 1'b0, 1'b1, 5'd1, 64'h15, 1'b1, 5'd2, 64'h24, 1'b0, 1'b1, "cont3");
    push(32'h4, 64'h24);
    idle("cont_after");
    chk("cont_last_grant", 64'(last_grant), 64'h1);

    // In-flight write, then two stalled cycles, then resume
    cyc(1'b0, 1'b0, 1'b1, 5'd1, 64'h31, 1'b1, 5'd2, 64'h42, 1'b1, 1'b0, "pre_stall");
    push(32'h2, 64'h31);
    cyc(1'b0, 1'b1, 1'b1, 5'd1, 64'h33, 1'b1, 5'd2, 64'h42, 1'b0, 1'b0, "stall1");
    cyc(1'b0, 1'b1, 1'b1, 5'd1, 64'h33, 1'b1, 5'd2, 64'h42, 1'b0, 1'b0, "stall2");
    chk("stall_drain_wr_en", 64'(wr_en), 64'h0);
    chk("stall_last_grant", 64'(last_grant), 64'h0);
    cyc(1'b0, 1'b0, 1'b1, 5'd1, 64'h33, 1'b1, 5'd2, 64'h42, 1'b0, 1'b1, "unstall");
    chk("stall2_wr_en", 64'(wr_en), 64'h0);
    push(32'h4, 64'h42);
    cyc(1'b0, 1'b0, 1'b1, 5'd1, 64'h33, 1'b0, '0, '0, 1'b1, 1'b0, "unstall_r0");
    push(32'h2, 64'h33);
    idle("unstall_after");

    // Reset in a cycle where req0 would otherwise be accepted
    cyc(1'b1, 1'b0, 1'b1, 5'd5, 64'h77, 1'b0, '0, '0, 1'b0, 1'b0, "rst_mid");
    cyc(1'b0, 1'b0, 1'b1, 5'd5, 64'h77, 1'b0, '0, '0, 1'b1, 1'b0, "rst_retry");
    chk("rst_mid_wr_en", 64'(wr_en), 64'h0);
    chk("rst_mid_wr_data", wr_data, 64'h0);
    chk("rst_mid_last_grant", 64'(last_grant), 64'h1);
    push(32'h0000_0020, 64'h77);
    idle("retry_after");
    chk("retry_last_grant", 64'(last_grant), 64'h0);
    idle("drain1");
    idle("drain2");
    chk("sb_empty", 64'(sb.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
